// File: rtl/state_sequencer.sv
// Next-state sequencer for the multicycle core: decodes the IR opcode and flags into
// a registered StateID, stalls on memory handshakes and walks the LM/SM register mask.
module state_sequencer #(
  parameter int STATE_W = 5,
  parameter int MASK_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        IR,
  input  logic               carry_flag,
  input  logic               zero_flag,
  input  logic               eq_flag,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] StateID,
  output logic               mem_req,
  output logic [2:0]         lm_index,
  output logic               instr_done,
  output logic               illegal_op
);

  localparam logic [STATE_W-1:0] S_FETCH      = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE     = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_ALU_RR     = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_WB_RR      = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_ALU_IMM    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_WB_IMM     = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_LHI        = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ADDR       = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_MEM_RD     = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_WB_MEM     = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_MEM_WR     = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_BEQ_CMP    = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_BR_TAKE    = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_JAL        = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_JLR        = STATE_W'(14);
  localparam logic [STATE_W-1:0] S_MULTI_SCAN = STATE_W'(15);
  localparam logic [STATE_W-1:0] S_MULTI_RD   = STATE_W'(16);
  localparam logic [STATE_W-1:0] S_MULTI_WB   = STATE_W'(17);
  localparam logic [STATE_W-1:0] S_MULTI_WR   = STATE_W'(18);
  localparam logic [STATE_W-1:0] S_PC_INC     = STATE_W'(19);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  logic [STATE_W-1:0] state_q, state_d;
  logic [MASK_W-1:0]  lm_mask_q, lm_mask_d;
  logic [2:0]         lm_index_q, lm_index_d;
  logic [2:0]         low_idx;
  logic               decode_illegal;
  logic [3:0]         opcode;
  logic               is_store;
  logic               unused_ir_bits;

  assign opcode = IR[15:12];
  // LW/SW and LM/SM differ only in the opcode LSB; IR is stable for the whole instruction.
  assign is_store = IR[12];
  assign unused_ir_bits = ^IR[11:MASK_W];

  // Lowest set bit wins: scanning downward lets the smallest index overwrite last.
  always_comb begin
    low_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (lm_mask_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves one unassigned (no latches).
    state_d        = state_q;
    lm_mask_d      = lm_mask_q;
    lm_index_d     = lm_index_q;
    decode_illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_NDU: begin
            case (IR[1:0])
              2'b00:   state_d = S_ALU_RR;
              2'b10:   state_d = carry_flag ? S_ALU_RR : S_PC_INC;
              2'b01:   state_d = zero_flag  ? S_ALU_RR : S_PC_INC;
              default: begin
                state_d        = S_PC_INC;
                decode_illegal = 1'b1;
              end
            endcase
          end
          OP_ADI:       state_d = S_ALU_IMM;
          OP_LHI:       state_d = S_LHI;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BEQ_CMP;
          OP_JAL:       state_d = S_JAL;
          OP_JLR:       state_d = S_JLR;
          OP_LM, OP_SM: begin
            state_d   = S_MULTI_SCAN;
            lm_mask_d = IR[MASK_W-1:0];
          end
          default: begin
            state_d        = S_PC_INC;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_ALU_RR:  state_d = S_WB_RR;
      S_WB_RR:   state_d = S_PC_INC;
      S_ALU_IMM: state_d = S_WB_IMM;
      S_WB_IMM:  state_d = S_PC_INC;
      S_LHI:     state_d = S_PC_INC;
      S_ADDR:    state_d = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM:  state_d = S_PC_INC;
      S_MEM_WR:  if (mem_ready) state_d = S_PC_INC;
      S_BEQ_CMP: state_d = eq_flag ? S_BR_TAKE : S_PC_INC;
      S_MULTI_SCAN: begin
        if (lm_mask_q == '0) begin
          state_d = S_PC_INC;
        end else begin
          lm_index_d = low_idx;
          lm_mask_d  = lm_mask_q & (lm_mask_q - MASK_W'(1));
          state_d    = is_store ? S_MULTI_WR : S_MULTI_RD;
        end
      end
      S_MULTI_RD: if (mem_ready) state_d = S_MULTI_WB;
      S_MULTI_WB: state_d = S_MULTI_SCAN;
      S_MULTI_WR: if (mem_ready) state_d = S_MULTI_SCAN;
      S_PC_INC, S_BR_TAKE, S_JAL, S_JLR: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      lm_mask_q  <= '0;
      lm_index_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state registers update together on the edge.
      state_q    <= state_d;
      lm_mask_q  <= lm_mask_d;
      lm_index_q <= lm_index_d;
    end
  end

  assign StateID    = state_q;
  assign lm_index   = lm_index_q;
  assign illegal_op = decode_illegal;
  assign mem_req    = (state_q == S_FETCH)    || (state_q == S_MEM_RD)   ||
                      (state_q == S_MEM_WR)   || (state_q == S_MULTI_RD) ||
                      (state_q == S_MULTI_WR);
  assign instr_done = (state_q == S_PC_INC)   || (state_q == S_BR_TAKE)  ||
                      (state_q == S_JAL)      || (state_q == S_JLR);

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: per-cycle expectations are queued with the
// stimulus that goes with them, then popped and compared one clock at a time.
module tb_state_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] IR;
  logic        carry_flag;
  logic        zero_flag;
  logic        eq_flag;
  logic        mem_ready;
  logic [4:0]  StateID;
  logic        mem_req;
  logic [2:0]  lm_index;
  logic        instr_done;
  logic        illegal_op;

  state_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .IR         (IR),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .eq_flag    (eq_flag),
    .mem_ready  (mem_ready),
    .StateID    (StateID),
    .mem_req    (mem_req),
    .lm_index   (lm_index),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One entry per cycle: expected outputs in that state, plus the inputs held during it.
  typedef struct {
    logic [4:0] st;
    logic       ill;
    logic [2:0] idx;
    logic       idx_chk;
    logic       mr;
    logic       eq;
    logic       cf;
    logic       zf;
  } ent_t;

  ent_t  sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    step     = 0;
  string test_name = "reset";
  logic  cur_cf = 1'b0;
  logic  cur_zf = 1'b0;

  function automatic logic exp_mem_req(input logic [4:0] s);
    return (s == 5'd0) || (s == 5'd8) || (s == 5'd10) || (s == 5'd16) || (s == 5'd18);
  endfunction

  function automatic logic exp_done(input logic [4:0] s);
    return (s == 5'd19) || (s == 5'd12) || (s == 5'd13) || (s == 5'd14);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int st, input logic mr = 1'b1, input logic eq = 1'b0,
                      input logic ill = 1'b0, input int idx = -1);
    ent_t e;
    e.st      = 5'(st);
    e.mr      = mr;
    e.eq      = eq;
    e.ill     = ill;
    e.idx_chk = (idx >= 0);
    e.idx     = 3'(idx);
    e.cf      = cur_cf;
    e.zf      = cur_zf;
    sb.push_back(e);
  endtask

  task automatic begin_instr(input string name, input logic [15:0] ir);
    test_name = name;
    step      = 0;
    IR        = ir;
  endtask

  // Called at a falling edge: compare the state now showing, then drive its inputs.
  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s#%0d StateID", test_name, step), 32'(StateID), 32'(e.st));
      check($sformatf("%s#%0d mem_req", test_name, step), 32'(mem_req), 32'(exp_mem_req(e.st)));
      check($sformatf("%s#%0d instr_done", test_name, step), 32'(instr_done), 32'(exp_done(e.st)));
      check($sformatf("%s#%0d illegal_op", test_name, step), 32'(illegal_op), 32'(e.ill));
      if (e.idx_chk)
        check($sformatf("%s#%0d lm_index", test_name, step), 32'(lm_index), 32'(e.idx));
      mem_ready  = e.mr;
      eq_flag    = e.eq;
      carry_flag = e.cf;
      zero_flag  = e.zf;
      step++;
      @(negedge clk);
    end
  endtask

  // Assert reset between edges and confirm the sequencer returns to FETCH at once.
  task automatic async_reset_check(input string name);
    #2 reset = 1'b1;
    #1;
    check({name, " StateID"},    32'(StateID),       32'd0);
    check({name, " mem_req"},    32'(mem_req),       32'd1);
    check({name, " instr_done"}, 32'(instr_done),    32'd0);
    check({name, " lm_index"},   32'(lm_index),      32'd0);
    check({name, " lm_mask"},    32'(dut.lm_mask_q), 32'd0);
    @(negedge clk);
    check({name, " held"}, 32'(StateID), 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    IR         = 16'h0000;
    carry_flag = 1'b0;
    zero_flag  = 1'b0;
    eq_flag    = 1'b0;
    mem_ready  = 1'b0;
    #1;
    check("reset StateID",    32'(StateID),    32'd0);
    check("reset mem_req",    32'(mem_req),    32'd1);
    check("reset instr_done", 32'(instr_done), 32'd0);
    check("reset illegal_op", 32'(illegal_op), 32'd0);
    check("reset lm_index",   32'(lm_index),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    begin_instr("add", 16'h0298);
    push(0); push(1); push(2); push(3); push(19);
    drain();

    begin_instr("adc_nc", 16'h029A);
    push(0); push(1); push(19);
    drain();

    // Carry seen in DECODE then dropped: the ALU path must still complete.
    begin_instr("adc_c", 16'h029A);
    cur_cf = 1'b1; push(0); push(1);
    cur_cf = 1'b0; push(2); push(3); push(19);
    drain();

    begin_instr("adz_nz", 16'h0299);
    push(0); push(1); push(19);
    drain();

    begin_instr("adz_z", 16'h0299);
    cur_zf = 1'b1; push(0); push(1);
    cur_zf = 1'b0; push(2); push(3); push(19);
    drain();

    begin_instr("ndu_11", 16'h229B);
    push(0); push(1, 1'b1, 1'b0, 1'b1); push(19);
    drain();

    begin_instr("adi", 16'h1000);
    push(0); push(1); push(4); push(5); push(19);
    drain();

    begin_instr("lhi", 16'h3000);
    push(0); push(1); push(6); push(19);
    drain();

    begin_instr("lw_wait", 16'h4000);
    push(0); push(1); push(7);
    push(8, 1'b0); push(8, 1'b0); push(8, 1'b0); push(8, 1'b1);
    push(9); push(19);
    drain();

    begin_instr("sw", 16'h5000);
    push(0); push(1); push(7); push(10); push(19);
    drain();

    begin_instr("beq_t", 16'hC000);
    push(0); push(1); push(11, 1'b1, 1'b1); push(12);
    drain();

    begin_instr("beq_nt", 16'hC000);
    push(0); push(1); push(11, 1'b1, 1'b0); push(19);
    drain();

    begin_instr("jal_fwait", 16'h8000);
    push(0, 1'b0); push(0, 1'b1); push(1); push(13);
    drain();

    begin_instr("jlr", 16'h9000);
    push(0); push(1); push(14);
    drain();

    begin_instr("ill_1010", 16'hA000);
    push(0); push(1, 1'b1, 1'b0, 1'b1); push(19);
    drain();

    begin_instr("ill_1111", 16'hF000);
    push(0); push(1, 1'b1, 1'b0, 1'b1); push(19);
    drain();

    begin_instr("lm_85", 16'h6085);
    push(0); push(1); push(15);
    push(16, 1'b1, 1'b0, 1'b0, 0); push(17, 1'b1, 1'b0, 1'b0, 0); push(15, 1'b1, 1'b0, 1'b0, 0);
    push(16, 1'b1, 1'b0, 1'b0, 2); push(17, 1'b1, 1'b0, 1'b0, 2); push(15, 1'b1, 1'b0, 1'b0, 2);
    push(16, 1'b1, 1'b0, 1'b0, 7); push(17, 1'b1, 1'b0, 1'b0, 7); push(15, 1'b1, 1'b0, 1'b0, 7);
    push(19, 1'b1, 1'b0, 1'b0, 7);
    drain();

    begin_instr("lm_00", 16'h6000);
    push(0); push(1); push(15); push(19);
    drain();

    begin_instr("lm_ff", 16'h60FF);
    push(0); push(1); push(15);
    for (int i = 0; i < 8; i++) begin
      push(16, 1'b1, 1'b0, 1'b0, i);
      push(17, 1'b1, 1'b0, 1'b0, i);
      push(15, 1'b1, 1'b0, 1'b0, i);
    end
    push(19, 1'b1, 1'b0, 1'b0, 7);
    drain();

    begin_instr("sm_81", 16'h7081);
    push(0); push(1); push(15);
    push(18, 1'b0, 1'b0, 1'b0, 0); push(18, 1'b1, 1'b0, 1'b0, 0); push(15, 1'b1, 1'b0, 1'b0, 0);
    push(18, 1'b1, 1'b0, 1'b0, 7); push(15, 1'b1, 1'b0, 1'b0, 7);
    push(19);
    drain();

    // Stalled SM with bits still pending in the mask, then reset.
    begin_instr("rst_multi_wr", 16'h7006);
    push(0); push(1); push(15); push(18, 1'b0, 1'b0, 1'b0, 1);
    drain();
    async_reset_check("rst_multi_wr");

    begin_instr("rst_mem_wr", 16'h5000);
    push(0); push(1); push(7); push(10, 1'b0); push(10, 1'b0);
    drain();
    async_reset_check("rst_mem_wr");

    begin_instr("after_rst", 16'h0298);
    push(0); push(1); push(2); push(3); push(19); push(0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
